// File: rtl/riscv_32i_control_pkg.sv
// Control-path types shared by decode and execute in the riscv_32i core.
// Holds the ALU operation encoding and the single legality rule used by both stages.
package riscv_32i_control_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } alu_op_t;

  function automatic logic is_legal_alu_op(alu_op_t op);
    case (op)
      ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
      ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU: return 1'b1;
      default:                                      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit integer ALU for the riscv_32i core.
// Unknown encodings produce result=0 and zero=0 so callers can flag them separately.
module alu
  import riscv_32i_control_pkg::*;
(
  input  alu_op_t     i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  output logic [31:0] o_result,
  output logic        o_zero
);

  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;

  assign w_a_s = i_a;
  assign w_b_s = i_b;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:  o_result = i_a + i_b;
      ALU_SUB:  o_result = i_a - i_b;
      ALU_AND:  o_result = i_a & i_b;
      ALU_OR:   o_result = i_a | i_b;
      ALU_XOR:  o_result = i_a ^ i_b;
      ALU_SLL:  o_result = i_a << i_b[4:0];
      ALU_SRL:  o_result = i_a >> i_b[4:0];
      ALU_SRA:  o_result = w_a_s >>> i_b[4:0];
      ALU_SLT:  o_result = {31'b0, w_a_s < w_b_s};
      ALU_SLTU: o_result = {31'b0, i_a < i_b};
      default:  o_result = '0;
    endcase
  end

  // Zero is only meaningful for a legal op; illegal ops report zero=0.
  assign o_zero = is_legal_alu_op(i_op) && (o_result == '0);

endmodule

// File: rtl/alu_exec_stage_assert.sv
// Protocol and reset checks for alu_exec_stage, attached to every instance by bind.
// Observes ports and the internal push strobe only; drives nothing.
module alu_exec_stage_assert #(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input logic                   clk,
  input logic                   rst_n,
  input logic                   flush,
  input logic                   req_ready,
  input logic                   w_push,
  input logic                   rsp_valid,
  input logic                   rsp_ready,
  input logic [31:0]            rsp_result,
  input logic                   rsp_zero,
  input logic                   rsp_illegal,
  input logic [TAG_W-1:0]       rsp_tag,
  input logic [$clog2(DEPTH):0] occupancy
);

  localparam logic [$clog2(DEPTH):0] FULL_OCC = ($clog2(DEPTH)+1)'(DEPTH);

  a_occ_bound: assert property (@(posedge clk) disable iff (!rst_n)
    occupancy <= FULL_OCC);

  a_no_push_full: assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> (occupancy < FULL_OCC));

  a_rsp_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (rsp_valid && !rsp_ready && !flush) |=>
      ($stable(rsp_result) && $stable(rsp_zero) && $stable(rsp_illegal) &&
       $stable(rsp_tag) && rsp_valid));

  a_reset_quiet: assert property (@(posedge clk)
    !rst_n |-> (!req_ready && !rsp_valid && rsp_result == '0 && !rsp_zero &&
                !rsp_illegal && rsp_tag == '0 && occupancy == '0));

endmodule

bind alu_exec_stage alu_exec_stage_assert #(.DEPTH(DEPTH), .TAG_W(TAG_W)) u_assert (
  .clk         (clk),
  .rst_n       (rst_n),
  .flush       (flush),
  .req_ready   (req_ready),
  .w_push      (w_push),
  .rsp_valid   (rsp_valid),
  .rsp_ready   (rsp_ready),
  .rsp_result  (rsp_result),
  .rsp_zero    (rsp_zero),
  .rsp_illegal (rsp_illegal),
  .rsp_tag     (rsp_tag),
  .occupancy   (occupancy)
);

// File: rtl/alu_exec_stage.sv
// Execute stage: computes ALU ops in the accept cycle and returns them in order
// through a DEPTH-entry result buffer with independent request/response handshakes.
module alu_exec_stage
  import riscv_32i_control_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAG_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [3:0]               req_op,
  input  logic [31:0]              req_a,
  input  logic [31:0]              req_b,
  input  logic [TAG_W-1:0]         req_tag,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_result,
  output logic                     rsp_zero,
  output logic                     rsp_illegal,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [$clog2(DEPTH):0]   occupancy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef struct packed {
    logic [31:0]      result;
    logic             zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } entry_t;

  entry_t             r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wptr;
  logic [PTR_W-1:0]   r_rptr;
  logic [OCC_W-1:0]   r_occ;

  alu_op_t            w_op;
  logic [31:0]        w_alu_result;
  logic               w_alu_zero;
  entry_t             w_entry;
  logic               w_push;
  logic               w_pop;

  assign w_op = alu_op_t'(req_op);

  alu u_alu (
    .i_op     (w_op),
    .i_a      (req_a),
    .i_b      (req_b),
    .o_result (w_alu_result),
    .o_zero   (w_alu_zero)
  );

  assign w_entry.result  = w_alu_result;
  assign w_entry.zero    = w_alu_zero;
  assign w_entry.illegal = !is_legal_alu_op(w_op);
  assign w_entry.tag     = req_tag;

  // Handshakes: ready depends only on reset, flush and fill level, never on rsp_ready.
  assign req_ready = rst_n && !flush && (r_occ < FULL_OCC);
  assign rsp_valid = (r_occ != '0);
  assign w_push    = req_valid && req_ready;
  assign w_pop     = rsp_valid && rsp_ready && !flush;
  assign occupancy = r_occ;

  always_comb begin
    rsp_result  = '0;
    rsp_zero    = 1'b0;
    rsp_illegal = 1'b0;
    rsp_tag     = '0;
    if (rsp_valid) begin
      rsp_result  = r_mem[r_rptr].result;
      rsp_zero    = r_mem[r_rptr].zero;
      rsp_illegal = r_mem[r_rptr].illegal;
      rsp_tag     = r_mem[r_rptr].tag;
    end
  end

  // Buffer state: pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (flush) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wptr] <= w_entry;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_pop) r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_occ <= r_occ + 1'b1;
        2'b01:   r_occ <= r_occ - 1'b1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: doc/alu_exec_stage.md
# alu_exec_stage

Registered execute stage that issues operations to the combinational `alu` and returns results in order. It sits between decode/issue and writeback in the riscv_32i core. Requests enter on a valid/ready handshake and results leave through a DEPTH-entry in-order result buffer with its own valid/ready handshake. The stage adds an illegal-op flag and a tag that travels with each operation.

## Interface
- `DEPTH`, 2: result buffer entries; power of two, ≥2.
- `TAG_W`, 4: width of the request tag carried to the response.

- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  synchronous clear of all buffered results.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  stage can accept a request this cycle.
- `req_op`  in  4  `alu_op_t` operation.
- `req_a`  in  32  operand A.
- `req_b`  in  32  operand B.
- `req_tag`  in  TAG_W  caller tag.
- `rsp_valid`  out  1  head result valid.
- `rsp_ready`  in  1  consumer takes the head result.
- `rsp_result`  out  32  ALU result.
- `rsp_zero`  out  1  ALU zero flag.
- `rsp_illegal`  out  1  op was not a legal `alu_op_t` encoding.
- `rsp_tag`  out  TAG_W  tag of the head result.
- `occupancy`  out  $clog2(DEPTH)+1  buffered entry count.

## Operation
- **Accept rule.** A request is accepted on a rising edge where `req_valid && req_ready`.
  - `req_ready = !rst_n_low && !flush && (occupancy < DEPTH)`.
  - `req_ready` has no combinational dependence on `rsp_ready`.
- **Computation.** Operands drive the internal `alu` combinationally in the accept cycle. {result, zero, illegal, tag} is written at the buffer tail on that edge.
- **Illegal ops.** For an illegal op, the ALU output is used unchanged (result=0, zero=0) and `illegal=1`. For legal ops, `illegal=0`.
- **Pop rule.** Pop on an edge where `rsp_valid && rsp_ready`. Results leave strictly in accept order.
- **Push and pop in one cycle.** Both take effect, occupancy is unchanged, and the accepted entry lands behind any remaining entries.
- **Empty buffer.** `rsp_valid=0`, and `rsp_result`, `rsp_zero`, `rsp_illegal`, `rsp_tag` are forced to 0.
- **Flush.** On the next edge `occupancy=0` and pointers return to 0. A pop requested in the same cycle is discarded, and `req_ready` is 0 during flush, so no request is lost.
- **Pointer wrap.** Read/write pointers wrap modulo DEPTH. Full vs empty is resolved by `occupancy`, not pointer equality.
- **Reset values.** On `rst_n` low (asynchronous, any time, including mid-stream): `occupancy=0`, pointers 0, stored entries 0, `rsp_valid=0`, all `rsp_*` data 0, `req_ready=0`. `req_ready` rises combinationally after `rst_n` deasserts.

## Timing
- **Latency.** A request accepted at edge N is visible on `rsp_*` with `rsp_valid=1` after edge N (cycle N+1) when the buffer was empty. Otherwise it appears once all older entries have popped.
- **Throughput.** 1 op/cycle with `rsp_ready` held high.
- **Backpressure.** With `rsp_ready=0`, exactly DEPTH requests are accepted, then `req_ready=0` until a pop edge.
- **Response stability.** `rsp_*` is stable while `rsp_valid && !rsp_ready`.
- **No combinational paths.** No combinational path exists from `req_*` to `rsp_*`.

## Structure
- `riscv_32i_control_pkg` already provides `alu_op_t`. Add `function automatic logic is_legal_alu_op(alu_op_t op)` there so decode and this stage share one legality rule.
- The buffer-entry struct is local to the module, because it depends on TAG_W.
- Sub-module: the existing `alu`, instantiated once. Buffer storage and pointers are in-line.
- Assertions go in a bound `alu_exec_stage_assert`:
  - `occupancy ≤ DEPTH`.
  - No push when full.
  - `rsp_*` stable under stall.
  - All outputs 0 while `rst_n` is low.

## Test plan
- ADD a=5, b=7, tag=3, `rsp_ready=1` → next cycle `rsp_valid=1`, result=12, zero=0, illegal=0, tag=3.
- SUB a=0x10, b=0x10 → result=0, zero=1. SUB a=0, b=1 → result=0xFFFFFFFF, zero=0.
- `rsp_ready=0`, push tags 1, 2, 3 (DEPTH=2):
  - Tags 1 and 2 are accepted; `req_ready=0` with tag 3 held and `occupancy=2`.
  - Raise `rsp_ready`: tags 1, 2, 3 return in order, and tag 3 is accepted the cycle after the first pop.
- op=4'b1111 with a=0xDEAD, b=1 → result=0, zero=0, illegal=1.
- Two entries buffered, assert `flush` with a simultaneous `req_valid` → next cycle `rsp_valid=0`, `occupancy=0`, and the request is not accepted (`req_ready` was 0).
- Assert `rst_n=0` asynchronously mid-cycle with the buffer full → all outputs 0 immediately. After release, `req_ready=1` and the next ADD 1+1 returns 2.
